sha256_digest_serializer: RTL and testbench

//  Downstream stage of sha256_processor. Captures the 256-bit hash_out when done rises.

---
 rtl/sha256_digest_serializer.sv | 151 +++++++++++++++
 tb/tb_sha256_digest_serializer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_digest_serializer.sv
// Captures a 256-bit SHA-256 digest on the rising edge of done_in and streams it
// out MSB-first as raw bytes or lowercase ASCII hex under a valid/ready handshake.
module sha256_digest_serializer #(
    parameter int unsigned HEX_MODE       = 0,
    parameter int unsigned APPEND_NEWLINE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done_in,
    input  logic [255:0] hash_in,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overrun,
    input  logic         overrun_clr
);

    localparam int unsigned HASH_W = 256;
    localparam int unsigned CNT_W  = 7;
    localparam bit          HEX_EN = (HEX_MODE != 0);
    localparam bit          NL_EN  = HEX_EN && (APPEND_NEWLINE != 0);
    localparam int unsigned N      = !HEX_EN ? 32 : (NL_EN ? 65 : 64);
    localparam int unsigned SHIFT  = HEX_EN ? 4 : 8;
    localparam int unsigned NL_IDX = 64;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e              state_q, state_d;
    logic                done_q, done_d;
    logic [HASH_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                new_c;
    logic                xfer_c;
    logic                final_c;

    // Lowercase ASCII hex character for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h57 + {4'h0, n};
    endfunction

    // Next-state, capture/shift, overrun and registered-output computation.
    always_comb begin
        state_d     = state_q;
        done_d      = done_in;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;
        out_data_d  = 8'h00;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;

        new_c   = done_in & ~done_q;
        xfer_c  = out_valid_q & out_ready;
        final_c = xfer_c & out_last_q;

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (new_c) begin
                    shreg_d = hash_in;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (final_c) begin
                    // Back-to-back digest: a new capture on the last transfer is legal.
                    if (new_c) begin
                        shreg_d = hash_in;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer_c) begin
                        shreg_d = shreg_q << SHIFT;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    if (new_c) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the post-edge state so they are registered.
        if (state_d == SEND) begin
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            out_last_d  = (cnt_d == CNT_W'(N - 1));
            if (NL_EN && (cnt_d == CNT_W'(NL_IDX))) begin
                out_data_d = 8'h0A;
            end else if (HEX_EN) begin
                out_data_d = hex_char(shreg_d[HASH_W-1 -: 4]);
            end else begin
                out_data_d = shreg_d[HASH_W-1 -: 8];
            end
        end
    end

    // State and output registers; done_q resets high so a held done_in is not a new digest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Bench for sha256_digest_serializer: one binary instance and one hex+newline instance,
// each checked every cycle against a byte-queue model built from the digest value.
module tb_sha256_digest_serializer;

    localparam logic [255:0] H1 = 256'hffe054fe7ae0cb6dc65c3af9b61d5209f439851db43d0ba5997337df154668eb;
    localparam logic [255:0] H2 = 256'h00112233445566778899aabbccddeeff0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [255:0] H3 = ~H1;

    logic         clk = 1'b0;

    logic         rst_b, done_b, ready_b, clr_b;
    logic [255:0] hash_b;
    logic [7:0]   db;
    logic         vb, lb, busyb, ovb;

    logic         rst_h, done_h, ready_h, clr_h;
    logic [255:0] hash_h;
    logic [7:0]   dh;
    logic         vh, lh, busyh, ovh;

    int n_checks = 0;
    int n_pass   = 0;
    int b_pops   = 0;

    // Model queues: {last, byte} expected in order; logs of accepted bytes.
    logic [8:0] qb[$];
    logic [8:0] qh[$];
    logic [7:0] log_b[$];
    logic [7:0] log_h[$];

    sha256_digest_serializer #(.HEX_MODE(0), .APPEND_NEWLINE(0)) dut (
        .clk(clk), .rst(rst_b), .done_in(done_b), .hash_in(hash_b),
        .out_data(db), .out_valid(vb), .out_ready(ready_b), .out_last(lb),
        .busy(busyb), .overrun(ovb), .overrun_clr(clr_b)
    );

    sha256_digest_serializer #(.HEX_MODE(1), .APPEND_NEWLINE(1)) dut_hex (
        .clk(clk), .rst(rst_h), .done_in(done_h), .hash_in(hash_h),
        .out_data(dh), .out_valid(vh), .out_ready(ready_h), .out_last(lh),
        .busy(busyh), .overrun(ovh), .overrun_clr(clr_h)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void push_bin(input logic [255:0] h);
        for (int k = 0; k < 32; k++) qb.push_back({1'(k == 31), h[255 - 8*k -: 8]});
    endfunction

    function automatic void push_hex(input logic [255:0] h);
        string s;
        s = $sformatf("%064h", h);
        for (int k = 0; k < 64; k++) qh.push_back({1'b0, 8'(s[k])});
        qh.push_back({1'b1, 8'h0A});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_b(input int budget, input bit rnd);
        int n = 0;
        while (qb.size() > 0 && n < budget) begin
            step();
            if (rnd) ready_b = 1'($urandom_range(0, 1));
            n++;
        end
        if (qb.size() > 0) chk("b_drain_timeout", 0, 1);
        ready_b = 1'b1;
    endtask

    task automatic drain_h(input int budget);
        int n = 0;
        while (qh.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (qh.size() > 0) chk("h_drain_timeout", 0, 1);
    endtask

    task automatic wait_pops(input int target);
        int n = 0;
        while (b_pops < target && n < 200) begin
            step();
            n++;
        end
        if (b_pops < target) chk("b_pop_timeout", 0, 1);
    endtask

    // Consume model entries on each accepted transfer.
    always @(posedge clk) begin
        if (!rst_b && vb && ready_b) begin
            log_b.push_back(db);
            if (qb.size() > 0) void'(qb.pop_front());
            b_pops++;
        end
        if (!rst_h && vh && ready_h) begin
            log_h.push_back(dh);
            if (qh.size() > 0) void'(qh.pop_front());
        end
    end

    // Compare outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (!rst_b) begin
            if (vb) begin
                if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
                else begin
                    chk("b_data", 32'(db), 32'(qb[0][7:0]));
                    chk("b_last", 32'(lb), 32'(qb[0][8]));
                end
                chk("b_busy", 32'(busyb), 1);
            end else begin
                chk("b_idle_last", 32'(lb), 0);
                chk("b_idle_busy", 32'(busyb), 0);
            end
        end
        if (!rst_h) begin
            if (vh) begin
                if (qh.size() == 0) chk("h_spurious_valid", 1, 0);
                else begin
                    chk("h_data", 32'(dh), 32'(qh[0][7:0]));
                    chk("h_last", 32'(lh), 32'(qh[0][8]));
                end
                chk("h_busy", 32'(busyh), 1);
            end else begin
                chk("h_idle_last", 32'(lh), 0);
                chk("h_idle_busy", 32'(busyh), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_b = 1'b1; done_b = 1'b0; ready_b = 1'b1; clr_b = 1'b0; hash_b = '0;
        rst_h = 1'b1; done_h = 1'b0; ready_h = 1'b1; clr_h = 1'b0; hash_h = '0;
        step(); step();
        chk("rst_valid", 32'(vb), 0);
        chk("rst_last", 32'(lb), 0);
        chk("rst_data", 32'(db), 0);
        chk("rst_busy", 32'(busyb), 0);
        chk("rst_overrun", 32'(ovb), 0);
        chk("rst_hex_valid", 32'(vh), 0);
        rst_b = 1'b0; rst_h = 1'b0;
        step(); step();

        // T1: binary stream, ready always high; hash changes after capture are ignored.
        hash_b = H1; done_b = 1'b1; push_bin(H1); log_b.delete();
        chk("t1_pre_valid", 32'(vb), 0);
        step();
        done_b = 1'b0; hash_b = H3;
        chk("t1_latency", 32'(vb), 1);
        chk("t1_first", 32'(db), 32'h ff);
        drain_b(100, 1'b0);
        chk("t1_valid_after", 32'(vb), 0);
        chk("t1_busy_after", 32'(busyb), 0);
        chk("t1_count", 32'(log_b.size()), 32);
        if (log_b.size() == 32) begin
            chk("t1_b0", 32'(log_b[0]), 32'h ff);
            chk("t1_b1", 32'(log_b[1]), 32'h e0);
            chk("t1_b2", 32'(log_b[2]), 32'h 54);
            chk("t1_b3", 32'(log_b[3]), 32'h fe);
            chk("t1_b30", 32'(log_b[30]), 32'h 68);
            chk("t1_b31", 32'(log_b[31]), 32'h eb);
        end

        // T2: hex with trailing newline.
        hash_h = H1; done_h = 1'b1; push_hex(H1); log_h.delete();
        step();
        done_h = 1'b0;
        drain_h(200);
        chk("t2_count", 32'(log_h.size()), 65);
        if (log_h.size() == 65) begin
            chk("t2_c0", 32'(log_h[0]), 32'h 66);
            chk("t2_c1", 32'(log_h[1]), 32'h 66);
            chk("t2_c2", 32'(log_h[2]), 32'h 65);
            chk("t2_c3", 32'(log_h[3]), 32'h 30);
            chk("t2_c4", 32'(log_h[4]), 32'h 35);
            chk("t2_c5", 32'(log_h[5]), 32'h 34);
            chk("t2_c62", 32'(log_h[62]), 32'h 65);
            chk("t2_c63", 32'(log_h[63]), 32'h 62);
            chk("t2_c64", 32'(log_h[64]), 32'h 0a);
        end
        chk("t2_busy_after", 32'(busyh), 0);
        chk("t2_overrun", 32'(ovh), 0);

        // T3: pseudo-random backpressure; model check covers stall stability.
        void'($urandom(32'd1234));
        hash_b = H2; done_b = 1'b1; push_bin(H2); log_b.delete();
        step();
        done_b = 1'b0;
        drain_b(2000, 1'b1);
        chk("t3_count", 32'(log_b.size()), 32);
        chk("t3_busy_after", 32'(busyb), 0);

        // T4: second digest mid-stream is dropped; set beats clear on the same edge.
        hash_b = H1; done_b = 1'b1; push_bin(H1); b_pops = 0;
        step();
        done_b = 1'b0;
        wait_pops(10);
        hash_b = H2; done_b = 1'b1;
        step();
        done_b = 1'b0;
        chk("t4_overrun_set", 32'(ovb), 1);
        wait_pops(20);
        done_b = 1'b1; clr_b = 1'b1;
        step();
        done_b = 1'b0; clr_b = 1'b0;
        chk("t4_set_wins", 32'(ovb), 1);
        drain_b(100, 1'b0);
        chk("t4_overrun_held", 32'(ovb), 1);
        step(); step();
        chk("t4_no_restart", 32'(vb), 0);
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        chk("t4_cleared", 32'(ovb), 0);

        // T5: new digest rises on the final transfer edge.
        hash_b = H1; done_b = 1'b1; push_bin(H1);
        step();
        done_b = 1'b0;
        for (int n = 0; n < 100 && !lb; n++) step();
        chk("t5_reached_last", 32'(lb), 1);
        hash_b = H2; done_b = 1'b1; push_bin(H2);
        step();
        done_b = 1'b0;
        chk("t5_valid_next", 32'(vb), 1);
        chk("t5_first", 32'(db), 32'h 00);
        chk("t5_overrun", 32'(ovb), 0);
        drain_b(100, 1'b0);
        chk("t5_overrun_end", 32'(ovb), 0);

        // T6: reset mid-stream with done_in held high throughout.
        hash_b = H3; done_b = 1'b1; push_bin(H3); b_pops = 0;
        step();
        wait_pops(5);
        rst_b = 1'b1;
        #1;
        chk("t6_valid_drop", 32'(vb), 0);
        chk("t6_busy_drop", 32'(busyb), 0);
        qb.delete();
        step(); step();
        rst_b = 1'b0;
        repeat (10) step();
        chk("t6_no_restart", 32'(vb), 0);
        done_b = 1'b0;
        step();
        chk("t6_still_idle", 32'(vb), 0);
        hash_b = H1; done_b = 1'b1; push_bin(H1);
        step();
        done_b = 1'b0;
        chk("t6_restart", 32'(vb), 1);
        drain_b(100, 1'b0);
        chk("t6_busy_after", 32'(busyb), 0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
